uart_imem_loader: RTL and testbench
===================================

Name: uart_imem_loader

Overview:
- UART boot loader that sits directly upstream of the instruction memory's programming write port.
- Receives a framed program image over an 8N1 serial line, packs bytes little-endian into 32-bit words, and issues one-cycle word writes (WE/A/WD) into instruction memory.
- Holds the core off the memory bus (core_hold) while loading. The top level uses core_hold to select the loader address over the PC and to stall/reset the core.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200); minimum legal value 4.
- MAX_WORDS, 14, largest accepted word count; equals instruction memory depth.

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RST  in  1  asynchronous, active-high reset.
- rx  in  1  UART serial input, idle high, asynchronous to CLK.
- imem_we  out  1  one-cycle write strobe to instruction memory WE.
- imem_addr  out  32  byte address to memory A; {word_idx, 2'b00}; 0 when imem_we=0.
- imem_wd  out  32  write data to memory WD; 0 when imem_we=0.
- core_hold  out  1  high while a load is in progress; selects loader onto memory address mux.
- load_done  out  1  one-cycle pulse after the final word write.
- load_err  out  1  sticky error flag; cleared on next accepted sync byte or RST.

Behaviour:
- Reset values: imem_we=0, imem_addr=0, imem_wd=0, core_hold=0, load_done=0, load_err=0, FSM=IDLE. The resident program therefore runs out of reset.
- RX front end:
  - rx passes through a 2-flop synchroniser; reset value of both flops is 1.
  - A falling edge in RX_IDLE starts bit timing. At CLKS_PER_BIT/2 the line is re-sampled; if it is high, this is a glitch and the front end returns to idle.
  - 8 data bits are then sampled LSB first, each CLKS_PER_BIT apart, then the stop bit.
  - Stop=1: rx_valid pulses 1 cycle with rx_byte.
  - Stop=0: rx_ferr pulses 1 cycle and no rx_valid is issued. The front end waits for rx high before re-arming.
- Frame format: 0xA5 sync, then N (word count), then 4*N data bytes. Each word is sent LSB byte first.
- Loader FSM:
  - IDLE: ignore all bytes except 0xA5. On 0xA5: load_err<=0, go COUNT.
  - COUNT:
    - On byte N with 1<=N<=MAX_WORDS: latch N, word_idx<=0, byte_idx<=0, core_hold<=1, go DATA.
    - On N=0 or N>MAX_WORDS: load_err<=1, go IDLE; core_hold unchanged.
  - DATA: each rx_valid writes byte into bits [8*byte_idx+7 : 8*byte_idx] of the assembly register, then byte_idx++. The valid that completes byte 3 moves the FSM to WRITE.
  - WRITE: exactly one cycle with imem_we=1, imem_addr={word_idx,2'b00}, imem_wd=assembled word.
    - If word_idx==N-1: go DONE.
    - Else: word_idx++, byte_idx<=0, go DATA.
  - DONE: load_done=1 for this single cycle, core_hold<=0 (low from the next cycle), go IDLE.
- Latency: imem_we asserts 1 cycle after the rx_valid of the 4th byte of each word.
- Framing error in COUNT or DATA: load_err<=1, go IDLE, partial word discarded. core_hold stays 1 because memory may be partially overwritten; it is released only by a later successful load or by RST.
- Framing error in IDLE is ignored; load_err is not set.
- 0xA5 received inside COUNT/DATA is treated as data; there is no resynchronisation mid-frame.
- A byte arriving during WRITE/DONE cannot occur, since bytes are at least 10*CLKS_PER_BIT cycles apart. This is a requirement, not something handled in logic.
- RST asserted mid-load: all outputs return to reset values immediately (asynchronously); partially written memory is left as is.
- Widths: word_idx is 4 bits, byte_idx is 2 bits, the bit-timer is $clog2(CLKS_PER_BIT) bits.

Decomposition:
- Package loader_pkg: SYNC_BYTE=8'hA5, MAX_WORDS default, loader FSM state enum (IDLE, COUNT, DATA, WRITE, DONE), RX state enum (RX_IDLE, RX_START, RX_DATA, RX_STOP).
- One sub-module, uart_rx: synchroniser, bit timer, deserialiser. Ports: CLK, RST, rx, rx_valid, rx_byte[7:0], rx_ferr.
- Loader FSM and packer live in uart_imem_loader.

Test Plan:
- Load A5 02 93 00 10 00 37 03 00 80 -> imem_we pulses twice: (addr 0x0, wd 0x00100093) then (addr 0x4, wd 0x80000337). core_hold rises after byte 02 and falls the cycle after the load_done pulse.
- Bytes 00 FF 12 then A5 01 13 00 00 00 -> leading bytes ignored; a single write of 0x00000013 to addr 0x0; load_err=0.
- A5 0F (15 > MAX_WORDS) -> no imem_we, load_err=1, core_hold=0. A following A5 clears load_err.
- A5 01 then 2 data bytes, then a byte with stop bit forced 0 -> load_err=1, no write, core_hold stays 1. A subsequent good 1-word load clears load_err and drops core_hold.
- 0.3-bit low glitch on idle rx -> no rx_valid, no rx_ferr, FSM stays IDLE.
- RST asserted after the 6th data byte of a 3-word load -> all outputs 0 within the same cycle. A fresh load then writes starting from addr 0x0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared constants, state encodings and address helper for the UART
// instruction-memory boot loader.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE         = 8'hA5;
  localparam int         MAX_WORDS_DEFAULT = 14;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Word index to memory byte address.
  function automatic logic [31:0] word_addr(input logic [3:0] idx);
    return {26'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/uart_imem_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle
// rx_valid / rx_ferr pulses.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_ferr
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_TICK = TW'(CLKS_PER_BIT / 2 - 1);

  logic            r_sync1;
  logic            r_sync2;
  rx_state_t       r_state;
  logic [TW-1:0]   r_timer;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_wait_high;

  // Receive state machine; after a framing error it waits for a high line before re-arming.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= RX_IDLE;
      r_timer     <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'd0;
      r_wait_high <= 1'b0;
      rx_valid    <= 1'b0;
      rx_byte     <= 8'd0;
      rx_ferr     <= 1'b0;
    end else begin
      r_sync1  <= rx;
      r_sync2  <= r_sync1;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_timer <= '0;
          if (r_wait_high) begin
            if (r_sync2) r_wait_high <= 1'b0;
          end else if (!r_sync2) begin
            r_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_timer == HALF_TICK) begin
            r_timer   <= '0;
            r_bit_idx <= 3'd0;
            r_state   <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_timer == LAST_TICK) begin
            r_timer   <= '0;
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= RX_STOP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_timer == LAST_TICK) begin
            r_timer <= '0;
            r_state <= RX_IDLE;
            if (r_sync2) begin
              rx_valid <= 1'b1;
              rx_byte  <= r_shift;
            end else begin
              rx_ferr     <= 1'b1;
              r_wait_high <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_imem_loader.sv
// UART boot loader: parses A5/N/data frames, packs little-endian words and
// drives one-cycle instruction-memory writes while holding the core off.
module uart_imem_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int MAX_WORDS    = MAX_WORDS_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

  logic       w_rx_valid;
  logic [7:0] w_rx_byte;
  logic       w_rx_ferr;

  ld_state_t   r_state;
  logic [3:0]  r_n;
  logic [3:0]  r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_asm;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .CLK      (CLK),
    .RST      (RST),
    .rx       (rx),
    .rx_valid (w_rx_valid),
    .rx_byte  (w_rx_byte),
    .rx_ferr  (w_rx_ferr)
  );

  // Loader FSM; the write strobe is registered on the 4th byte so it is high during WRITE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_n        <= 4'd0;
      r_word_idx <= 4'd0;
      r_byte_idx <= 2'd0;
      r_asm      <= 32'd0;
      imem_we    <= 1'b0;
      imem_addr  <= 32'd0;
      imem_wd    <= 32'd0;
      core_hold  <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we   <= 1'b0;
      imem_addr <= 32'd0;
      imem_wd   <= 32'd0;
      load_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rx_valid && (w_rx_byte == SYNC_BYTE)) begin
            load_err <= 1'b0;
            r_state  <= COUNT;
          end
        end
        COUNT: begin
          if (w_rx_ferr) begin
            load_err <= 1'b1;
            r_state  <= IDLE;
          end else if (w_rx_valid) begin
            if ((w_rx_byte != 8'd0) && (w_rx_byte <= MAX_N)) begin
              r_n        <= w_rx_byte[3:0];
              r_word_idx <= 4'd0;
              r_byte_idx <= 2'd0;
              core_hold  <= 1'b1;
              r_state    <= DATA;
            end else begin
              load_err <= 1'b1;
              r_state  <= IDLE;
            end
          end
        end
        DATA: begin
          if (w_rx_ferr) begin
            load_err <= 1'b1;
            r_state  <= IDLE;
          end else if (w_rx_valid) begin
            r_asm[{r_byte_idx, 3'b000} +: 8] <= w_rx_byte;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              imem_we   <= 1'b1;
              imem_addr <= word_addr(r_word_idx);
              imem_wd   <= {w_rx_byte, r_asm[23:0]};
              r_state   <= WRITE;
            end
          end
        end
        WRITE: begin
          if (r_word_idx == (r_n - 4'd1)) begin
            load_done <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_word_idx <= r_word_idx + 4'd1;
            r_byte_idx <= 2'd0;
            r_state    <= DATA;
          end
        end
        DONE: begin
          core_hold <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader with a write scoreboard.
module tb_uart_imem_loader;
  import loader_pkg::*;

  localparam int CPB = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        rx  = 1'b1;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;
  logic        core_hold;
  logic        load_done;
  logic        load_err;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int rxv_cnt = 0;
  int ferr_cnt = 0;
  logic prev_done = 1'b0;
  logic [63:0] exp_q[$];
  logic [7:0]  tx_q[$];

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(14)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .rx        (rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wd   (imem_wd),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge CLK) rx = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge CLK);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge CLK);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge CLK);
  endtask

  task automatic flush_tx();
    while (tx_q.size() != 0) send_byte(tx_q.pop_front(), 1'b1);
  endtask

  // Output monitor: scoreboard for writes, done/hold relationship, rx pulse counts.
  always @(negedge CLK) begin
    if (!RST) begin
      if (imem_we) begin
        logic [63:0] e;
        we_cnt++;
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL unexp_write observed=%h/%h expected=none", imem_addr, imem_wd);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", imem_addr, e[63:32]);
          check("wr_data", imem_wd, e[31:0]);
        end
      end
      if (load_done) begin
        done_cnt++;
        check("hold_at_done", 32'(core_hold), 32'd1);
      end
      if (prev_done) check("hold_after_done", 32'(core_hold), 32'd0);
      prev_done = load_done;
      if (dut.w_rx_valid) rxv_cnt++;
      if (dut.w_rx_ferr) ferr_cnt++;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    int rxv0, ferr0;
    // Reset state
    repeat (4) @(negedge CLK);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wd", imem_wd, 32'd0);
    check("rst_hold", 32'(core_hold), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    // Two-word load
    exp_q.push_back({32'h0, 32'h00100093});
    exp_q.push_back({32'h4, 32'h80000337});
    send_byte(8'hA5, 1'b1);
    check("t1_hold_pre", 32'(core_hold), 32'd0);
    send_byte(8'h02, 1'b1);
    check("t1_hold_up", 32'(core_hold), 32'd1);
    tx_q = {8'h93, 8'h00, 8'h10, 8'h00, 8'h37, 8'h03, 8'h00, 8'h80};
    flush_tx();
    check("t1_we_cnt", 32'(we_cnt), 32'd2);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_hold_down", 32'(core_hold), 32'd0);
    check("t1_err", 32'(load_err), 32'd0);

    // Leading junk then one-word load
    exp_q.push_back({32'h0, 32'h00000013});
    tx_q = {8'h00, 8'hFF, 8'h12, 8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00};
    flush_tx();
    check("t2_we_cnt", 32'(we_cnt), 32'd3);
    check("t2_err", 32'(load_err), 32'd0);
    check("t2_hold", 32'(core_hold), 32'd0);

    // Count out of range
    tx_q = {8'hA5, 8'h0F};
    flush_tx();
    check("t3_we_cnt", 32'(we_cnt), 32'd3);
    check("t3_err", 32'(load_err), 32'd1);
    check("t3_hold", 32'(core_hold), 32'd0);
    send_byte(8'hA5, 1'b1);
    check("t3_err_clr", 32'(load_err), 32'd0);
    send_byte(8'h00, 1'b1);
    check("t3_zero_err", 32'(load_err), 32'd1);

    // Framing error mid-word, then recovery
    tx_q = {8'hA5, 8'h01, 8'h11, 8'h22};
    flush_tx();
    send_byte(8'h33, 1'b0);
    check("t4_err", 32'(load_err), 32'd1);
    check("t4_hold", 32'(core_hold), 32'd1);
    check("t4_we_cnt", 32'(we_cnt), 32'd3);
    check("t4_state", 32'(dut.r_state), 32'(IDLE));
    exp_q.push_back({32'h0, 32'h11223344});
    tx_q = {8'hA5, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11};
    flush_tx();
    check("t4_rec_err", 32'(load_err), 32'd0);
    check("t4_rec_hold", 32'(core_hold), 32'd0);
    check("t4_rec_done", 32'(done_cnt), 32'd3);

    // Short glitch on idle line
    rxv0 = rxv_cnt;
    ferr0 = ferr_cnt;
    @(negedge CLK) rx = 1'b0;
    repeat (CPB * 3 / 10) @(negedge CLK);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge CLK);
    check("gl_valid", 32'(rxv_cnt - rxv0), 32'd0);
    check("gl_ferr", 32'(ferr_cnt - ferr0), 32'd0);
    check("gl_state", 32'(dut.r_state), 32'(IDLE));

    // Reset in the middle of a three-word load
    exp_q.push_back({32'h0, 32'h04030201});
    tx_q = {8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    flush_tx();
    check("t6_hold_pre", 32'(core_hold), 32'd1);
    @(negedge CLK) RST = 1'b1;
    #1;
    check("t6_we", 32'(imem_we), 32'd0);
    check("t6_addr", imem_addr, 32'd0);
    check("t6_wd", imem_wd, 32'd0);
    check("t6_hold", 32'(core_hold), 32'd0);
    check("t6_done", 32'(load_done), 32'd0);
    check("t6_err", 32'(load_err), 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    exp_q.push_back({32'h0, 32'hEFBEADDE});
    tx_q = {8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    flush_tx();
    check("t6_we_cnt", 32'(we_cnt), 32'd6);
    check("t6_done_cnt", 32'(done_cnt), 32'd4);
    check("t6_hold_end", 32'(core_hold), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
